// File: rtl/debug_word_printer_pkg.sv
// Shared constants, state encoding and helpers for the debugger word printer.
// The trailer states are only reached when DEBUG_WORD_PRINTER_TRAILER_EN is defined.
package debug_word_printer_pkg;

    localparam int DEFAULT_UART_BUS_SIZE = 8;
    localparam int DEFAULT_WORD_SIZE     = 32;
    localparam int DEFAULT_WORD_COUNT    = 32;
    localparam int DEFAULT_CHANNELS      = 2;

    localparam logic [7:0] DEBUGGER_INFO_PREFIX    = 8'hD1;
    localparam logic [7:0] DEBUGGER_TRAILER_PREFIX = 8'hD7;

    typedef enum logic [2:0] {
        DEBUG_WORD_PRINTER_STATE_IDLE,
        DEBUG_WORD_PRINTER_STATE_SEND,
        DEBUG_WORD_PRINTER_STATE_WAIT,
        DEBUG_WORD_PRINTER_STATE_TRAILER,
        DEBUG_WORD_PRINTER_STATE_WAIT_T,
        DEBUG_WORD_PRINTER_STATE_DONE
    } printer_state_t;

    // A single-bank build still needs a 1-bit channel port.
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/debug_word_select.sv
// Combinational (channel, index) -> word mux over the flattened bank bus.
// Out-of-range channel or index reads as zero.
module debug_word_select
    import debug_word_printer_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int WORD_COUNT = DEFAULT_WORD_COUNT,
    parameter int CHANNELS   = DEFAULT_CHANNELS,
    localparam int IDX_W     = $clog2(WORD_COUNT),
    localparam int CH_W      = ch_width(CHANNELS)
) (
    input  logic [CHANNELS*WORD_COUNT*WORD_SIZE-1:0] words,
    input  logic [CH_W-1:0]                          channel,
    input  logic [IDX_W-1:0]                         index,
    output logic [WORD_SIZE-1:0]                     word
);

    always_comb begin
        word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int w = 0; w < WORD_COUNT; w++) begin
                if (int'(channel) == c && int'(index) == w) begin
                    word = words[(c*WORD_COUNT+w)*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

endmodule

// File: rtl/debug_word_printer.sv
// Debugger-side serializer: dumps an index range of one bank as one UART frame per word.
// Define DEBUG_WORD_PRINTER_TRAILER_EN to append a trailer frame carrying the frame count.
module debug_word_printer
    import debug_word_printer_pkg::*;
#(
    parameter int UART_BUS_SIZE      = DEFAULT_UART_BUS_SIZE,
    parameter int WORD_SIZE          = DEFAULT_WORD_SIZE,
    parameter int WORD_COUNT         = DEFAULT_WORD_COUNT,
    parameter int CHANNELS           = DEFAULT_CHANNELS,
    localparam int DATA_OUT_BUS_SIZE = 4*UART_BUS_SIZE + WORD_SIZE,
    localparam int IDX_W             = $clog2(WORD_COUNT),
    localparam int CH_W              = ch_width(CHANNELS)
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic                                     i_start,
    input  logic [CH_W-1:0]                          i_channel,
    input  logic [IDX_W-1:0]                         i_first,
    input  logic [IDX_W-1:0]                         i_last,
    input  logic [CHANNELS*WORD_COUNT*WORD_SIZE-1:0] i_words,
    input  logic [UART_BUS_SIZE-1:0]                 i_clk_cicle,
    input  logic                                     i_wr_end,
    output logic                                     o_start_wr,
    output logic [DATA_OUT_BUS_SIZE-1:0]             o_data_wr,
    output logic                                     o_busy,
    output logic                                     o_end
);

    localparam logic [UART_BUS_SIZE-1:0] INFO_PREFIX    = UART_BUS_SIZE'(DEBUGGER_INFO_PREFIX);
    localparam logic [UART_BUS_SIZE-1:0] TRAILER_PREFIX = UART_BUS_SIZE'(DEBUGGER_TRAILER_PREFIX);
    localparam int LAST_IDX = WORD_COUNT - 1;

`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
    localparam printer_state_t AFTER_LAST = DEBUG_WORD_PRINTER_STATE_TRAILER;
`else
    localparam printer_state_t AFTER_LAST = DEBUG_WORD_PRINTER_STATE_DONE;
`endif

    printer_state_t               state_q, state_d;
    logic [IDX_W:0]               pointer_q, pointer_d;
    logic [IDX_W:0]               last_q, last_d;
    logic [CH_W-1:0]              channel_q, channel_d;
    logic [UART_BUS_SIZE-1:0]     cycle_q, cycle_d;
    logic                         start_wr_d, end_d, busy_d;
    logic [DATA_OUT_BUS_SIZE-1:0] data_wr_d;
    logic [WORD_SIZE-1:0]         sel_word;
    logic [IDX_W:0]               max_idx;
    logic [IDX_W:0]               eff_last;
    logic                         empty_range;
`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
    logic [UART_BUS_SIZE-1:0]     frames_q, frames_d;
`endif

    debug_word_select #(
        .WORD_SIZE  (WORD_SIZE),
        .WORD_COUNT (WORD_COUNT),
        .CHANNELS   (CHANNELS)
    ) u_select (
        .words   (i_words),
        .channel (channel_q),
        .index   (pointer_q[IDX_W-1:0]),
        .word    (sel_word)
    );

    // Clamp the requested range to the bank and reject unknown channels up front.
    assign max_idx     = LAST_IDX[IDX_W:0];
    assign eff_last    = ({1'b0, i_last} > max_idx) ? max_idx : {1'b0, i_last};
    assign empty_range = ({1'b0, i_first} > eff_last) || (int'(i_channel) >= CHANNELS);

    always_comb begin
        state_d    = state_q;
        pointer_d  = pointer_q;
        last_d     = last_q;
        channel_d  = channel_q;
        cycle_d    = cycle_q;
        start_wr_d = 1'b0;
        end_d      = 1'b0;
        busy_d     = o_busy;
        data_wr_d  = o_data_wr;
`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
        frames_d   = frames_q;
`endif
        case (state_q)
            DEBUG_WORD_PRINTER_STATE_IDLE: begin
                if (i_start) begin
                    channel_d = i_channel;
                    cycle_d   = i_clk_cicle;
                    pointer_d = {1'b0, i_first};
                    last_d    = eff_last;
                    busy_d    = 1'b1;
`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
                    frames_d  = '0;
`endif
                    state_d   = empty_range ? AFTER_LAST : DEBUG_WORD_PRINTER_STATE_SEND;
                end
            end
            DEBUG_WORD_PRINTER_STATE_SEND: begin
                data_wr_d  = {INFO_PREFIX, UART_BUS_SIZE'(channel_q), cycle_q,
                              UART_BUS_SIZE'(pointer_q), sel_word};
                start_wr_d = 1'b1;
`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
                frames_d   = frames_q + 1'b1;
`endif
                state_d    = DEBUG_WORD_PRINTER_STATE_WAIT;
            end
            // A completion that overlaps our own start pulse belongs to the previous frame.
            DEBUG_WORD_PRINTER_STATE_WAIT: begin
                if (i_wr_end && !o_start_wr) begin
                    if (pointer_q == last_q) begin
                        state_d = AFTER_LAST;
                    end else begin
                        pointer_d = pointer_q + 1'b1;
                        state_d   = DEBUG_WORD_PRINTER_STATE_SEND;
                    end
                end
            end
`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
            DEBUG_WORD_PRINTER_STATE_TRAILER: begin
                data_wr_d  = {TRAILER_PREFIX, UART_BUS_SIZE'(channel_q), cycle_q,
                              frames_q, {WORD_SIZE{1'b0}}};
                start_wr_d = 1'b1;
                state_d    = DEBUG_WORD_PRINTER_STATE_WAIT_T;
            end
            DEBUG_WORD_PRINTER_STATE_WAIT_T: begin
                if (i_wr_end && !o_start_wr) begin
                    state_d = DEBUG_WORD_PRINTER_STATE_DONE;
                end
            end
`endif
            DEBUG_WORD_PRINTER_STATE_DONE: begin
                end_d     = 1'b1;
                busy_d    = 1'b0;
                pointer_d = '0;
                state_d   = DEBUG_WORD_PRINTER_STATE_IDLE;
            end
            default: begin
                state_d = DEBUG_WORD_PRINTER_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= DEBUG_WORD_PRINTER_STATE_IDLE;
            pointer_q  <= '0;
            last_q     <= '0;
            channel_q  <= '0;
            cycle_q    <= '0;
            o_start_wr <= 1'b0;
            o_end      <= 1'b0;
            o_busy     <= 1'b0;
            o_data_wr  <= '0;
`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
            frames_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pointer_q  <= pointer_d;
            last_q     <= last_d;
            channel_q  <= channel_d;
            cycle_q    <= cycle_d;
            o_start_wr <= start_wr_d;
            o_end      <= end_d;
            o_busy     <= busy_d;
            o_data_wr  <= data_wr_d;
`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
            frames_q   <= frames_d;
`endif
        end
    end

endmodule

// File: tb/tb_debug_word_printer.sv
// Scoreboard bench for debug_word_printer: a model queues expected frames per dump,
// a monitor pops and compares them whenever the printer raises o_start_wr.
module tb_debug_word_printer;

    localparam int WORD_SIZE  = 32;
    localparam int WORD_COUNT = 32;
    localparam int CHANNELS   = 2;
    localparam int IDX_W      = 5;
    localparam int CH_W       = 1;
    localparam int DW         = 64;
    localparam logic [7:0] INFO_PREFIX    = 8'hD1;
    localparam logic [7:0] TRAILER_PREFIX = 8'hD7;

    logic                                     clk = 1'b0;
    logic                                     reset = 1'b1;
    logic                                     start = 1'b0;
    logic [CH_W-1:0]                          channel = '0;
    logic [IDX_W-1:0]                         first = '0;
    logic [IDX_W-1:0]                         last = '0;
    logic [CHANNELS*WORD_COUNT*WORD_SIZE-1:0] words = '0;
    logic [7:0]                               cycle = '0;
    logic                                     wr_end = 1'b0;
    logic                                     start_wr;
    logic [DW-1:0]                            data_wr;
    logic                                     busy;
    logic                                     end_pulse;

    debug_word_printer dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_channel   (channel),
        .i_first     (first),
        .i_last      (last),
        .i_words     (words),
        .i_clk_cicle (cycle),
        .i_wr_end    (wr_end),
        .o_start_wr  (start_wr),
        .o_data_wr   (data_wr),
        .o_busy      (busy),
        .o_end       (end_pulse)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q[$];
    int            ends_expected = 0;
    int            frames_seen = 0;
    int            ncycle = 0;
    int            due_q[$];
    int            hold_cnt = 0;
    int            resp_delay = 5;
    int            resp_hold = 1;
    time           start_time;
    time           evt_time;
    bit            evt_seen = 1'b0;
    logic [31:0]   mem [CHANNELS][WORD_COUNT];

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pack_words();
        for (int c = 0; c < CHANNELS; c++)
            for (int w = 0; w < WORD_COUNT; w++)
                words[(c*WORD_COUNT+w)*WORD_SIZE +: WORD_SIZE] = mem[c][w];
    endtask

    // UART stand-in plus scoreboard monitor, both sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            ncycle++;
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) wr_end = 1'b0;
            end
            if (start_wr) due_q.push_back(ncycle + resp_delay);
            if (due_q.size() > 0 && hold_cnt == 0 && due_q[0] <= ncycle) begin
                void'(due_q.pop_front());
                wr_end   = 1'b1;
                hold_cnt = resp_hold;
            end
            if (start_wr) begin
                frames_seen++;
                if (!evt_seen) begin evt_seen = 1'b1; evt_time = $time; end
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_frame: got %h, expected no frame", data_wr);
                end else begin
                    check_output("frame", data_wr, exp_q.pop_front());
                end
            end
            if (end_pulse) begin
                if (!evt_seen) begin evt_seen = 1'b1; evt_time = $time; end
                tests++;
                if (ends_expected == 0 || exp_q.size() != 0) begin
                    fails++;
                    $display("[TB] FAIL end_pulse: got end with %0d frames pending, %0d ends expected",
                             exp_q.size(), ends_expected);
                end else begin
                    ends_expected--;
                end
            end
        end
    end

    // Reference model: one frame per index of the clamped range, cycle frozen at start.
    task automatic apply_stimulus(input int ch, input int f, input int l, input logic [7:0] cyc,
                                  input bit mid_start);
        int eff;
        int n;
        int cycles;
        bit ended;
        eff = (l > WORD_COUNT-1) ? WORD_COUNT-1 : l;
        n = 0;
        for (int i = f; i <= eff; i++) begin
            exp_q.push_back({INFO_PREFIX, 8'(ch), cyc, 8'(i), mem[ch][i]});
            n++;
        end
`ifdef DEBUG_WORD_PRINTER_TRAILER_EN
        exp_q.push_back({TRAILER_PREFIX, 8'(ch), cyc, 8'(n), 32'h0});
`endif
        ends_expected++;
        @(negedge clk);
        channel    = CH_W'(ch);
        first      = IDX_W'(f);
        last       = IDX_W'(l);
        cycle      = cyc;
        start      = 1'b1;
        start_time = $time;
        evt_seen   = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        ended  = 1'b0;
        cycles = 0;
        while (!ended && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            cycle = 8'($urandom);
            if (end_pulse) ended = 1'b1;
            else start = mid_start && busy && ($urandom_range(0, 2) == 0);
        end
        start = 1'b0;
        check_output("end_seen", 64'(ended), 64'd1);
        @(negedge clk);
        check_output("first_latency", 64'(evt_seen ? (evt_time - start_time) / 10 : 0), 64'd2);
        check_output("busy_after", 64'(busy), 64'd0);
        check_output("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int cycles;
        int f;
        int l;
        for (int c = 0; c < CHANNELS; c++)
            for (int w = 0; w < WORD_COUNT; w++)
                mem[c][w] = $urandom;
        for (int w = 0; w < WORD_COUNT; w++) mem[0][w] = 32'(w * 3);
        pack_words();

        repeat (3) @(negedge clk);
        check_output("reset_outputs", {start_wr, end_pulse, busy, 61'(data_wr)}, 64'd0);
        check_output("reset_data", data_wr, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        apply_stimulus(0, 0, 31, 8'h11, 1'b0);
        apply_stimulus(1, 4, 6, 8'h2A, 1'b0);
        apply_stimulus(0, 5, 2, 8'h33, 1'b0);
        apply_stimulus(1, 31, 31, 8'h44, 1'b0);
        apply_stimulus(0, 0, 0, 8'h45, 1'b0);
        apply_stimulus(1, 30, 31, 8'h46, 1'b0);

        resp_delay = 2;
        resp_hold  = 3;
        apply_stimulus(0, 2, 12, 8'h5A, 1'b1);

        // Abort a dump while waiting for the second frame's completion.
        resp_delay = 6;
        resp_hold  = 1;
        for (int i = 3; i <= 20; i++) exp_q.push_back({INFO_PREFIX, 8'd1, 8'h5C, 8'(i), mem[1][i]});
        ends_expected++;
        base = frames_seen;
        @(negedge clk);
        channel = 1'b1; first = 5'd3; last = 5'd20; cycle = 8'h5C; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (frames_seen < base + 2 && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        check_output("two_frames_before_reset", 64'(frames_seen - base >= 2), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        ends_expected = 0;
        @(negedge clk);
        reset = 1'b0;
        check_output("abort_outputs", {start_wr, end_pulse, busy, 61'(data_wr)}, 64'd0);
        check_output("abort_data", data_wr, 64'd0);
        base = frames_seen;
        repeat (30) @(negedge clk);
        check_output("no_frames_after_reset", 64'(frames_seen - base), 64'd0);
        apply_stimulus(1, 3, 5, 8'h77, 1'b0);

        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int w = 0; w < WORD_COUNT; w++)
                    mem[c][w] = $urandom;
            pack_words();
            resp_delay = $urandom_range(1, 6);
            resp_hold  = $urandom_range(1, 3);
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            if ($urandom_range(0, 3) != 0 && f > l) begin
                int t;
                t = f; f = l; l = t;
            end
            apply_stimulus($urandom_range(0, 1), f, l, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
